// File: rtl/mod_share_arbiter.sv
// Shares one registered MOD operator among NR requesters: per-requester operand-join slots,
// round-robin dispatch of one full slot per cycle, and tagged result return.
module mod_share_arbiter #(
   parameter int unsigned N  = 16,
   parameter int unsigned NR = 4,
   parameter int unsigned TW = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            EN,
   input  logic [NR-1:0]   REQ_R1,
   input  logic [NR*N-1:0] REQ_D1,
   input  logic [NR-1:0]   REQ_R2,
   input  logic [NR*N-1:0] REQ_D2,
   output logic [NR-1:0]   REQ_ACK1,
   output logic [NR-1:0]   REQ_ACK2,
   output logic            OP_EN,
   output logic            OP_R_IN1,
   output logic [N-1:0]    OP_D_IN1,
   output logic            OP_R_IN2,
   output logic [N-1:0]    OP_D_IN2,
   input  logic            OP_R_OUT,
   input  logic [N-1:0]    OP_D_OUT,
   output logic [NR-1:0]   RES_R,
   output logic [NR*N-1:0] RES_D
);

   logic [NR-1:0]   full1_q, full2_q;
   logic [N-1:0]    opa_q [NR];
   logic [N-1:0]    opb_q [NR];
   logic [TW-1:0]   rr_q;
   logic [TW-1:0]   tag_q;
   logic            tag_valid_q;
   logic [NR-1:0]   res_r_q;
   logic [NR*N-1:0] res_d_q;

   logic [NR-1:0]   cand;
   logic [NR-1:0]   grant_oh;
   logic            grant_valid;
   logic [TW-1:0]   grant_idx;

   // Round-robin search starting one past the last winner.
   always_comb begin
      logic [TW-1:0] idx;
      cand        = EN ? (full1_q & full2_q) : '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_oh    = '0;
      idx         = '0;
      for (int k = 1; k <= int'(NR); k++) begin
         idx = TW'((int'(rr_q) + k) % NR);
         if (!grant_valid && cand[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
      if (grant_valid) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   // A slot being dispatched this cycle may be refilled in the same cycle.
   assign REQ_ACK1 = {NR{EN & RST}} & REQ_R1 & (~full1_q | grant_oh);
   assign REQ_ACK2 = {NR{EN & RST}} & REQ_R2 & (~full2_q | grant_oh);

   assign OP_EN    = EN & RST;
   assign OP_R_IN1 = grant_valid;
   assign OP_R_IN2 = grant_valid;
   assign OP_D_IN1 = grant_valid ? opa_q[grant_idx] : '0;
   assign OP_D_IN2 = grant_valid ? opb_q[grant_idx] : '0;

   assign RES_R = res_r_q;
   assign RES_D = res_d_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         full1_q <= '0;
         full2_q <= '0;
         for (int i = 0; i < int'(NR); i++) begin
            opa_q[i] <= '0;
            opb_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NR); i++) begin
            if (REQ_ACK1[i]) begin
               full1_q[i] <= 1'b1;
               opa_q[i]   <= REQ_D1[i*N +: N];
            end else if (grant_oh[i]) begin
               full1_q[i] <= 1'b0;
            end
            if (REQ_ACK2[i]) begin
               full2_q[i] <= 1'b1;
               opb_q[i]   <= REQ_D2[i*N +: N];
            end else if (grant_oh[i]) begin
               full2_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rr_q        <= TW'(NR - 1);
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
      end else begin
         tag_valid_q <= grant_valid;
         if (grant_valid) begin
            rr_q  <= grant_idx;
            tag_q <= grant_idx;
         end
      end
   end

   // The operator holds its output while disabled, so return does not wait for EN.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         res_r_q <= '0;
         res_d_q <= '0;
      end else begin
         res_r_q <= '0;
         if (tag_valid_q) begin
            res_r_q[tag_q]          <= 1'b1;
            res_d_q[tag_q*N +: N]   <= OP_D_OUT;
         end
      end
   end

   a_result_valid: assert property (@(posedge CLK) disable iff (!RST) tag_valid_q |-> OP_R_OUT);

endmodule

// File: tb/tb_mod_share_arbiter.sv
// Bench for mod_share_arbiter: directed scenarios with fixed expectations plus a randomized
// run checked against a cycle-level behavioural model of the sharing rules.
module tb_mod_share_arbiter;
   localparam int N  = 16;
   localparam int NR = 4;
   localparam int TW = 2;

   logic            CLK, RST, EN;
   logic [NR-1:0]   REQ_R1, REQ_R2, REQ_ACK1, REQ_ACK2, RES_R;
   logic [NR*N-1:0] REQ_D1, REQ_D2, RES_D;
   logic            OP_EN, OP_R_IN1, OP_R_IN2, OP_R_OUT;
   logic [N-1:0]    OP_D_IN1, OP_D_IN2, OP_D_OUT;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   mod_share_arbiter #(.N(N), .NR(NR), .TW(TW)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .REQ_R1(REQ_R1), .REQ_D1(REQ_D1), .REQ_R2(REQ_R2), .REQ_D2(REQ_D2),
      .REQ_ACK1(REQ_ACK1), .REQ_ACK2(REQ_ACK2),
      .OP_EN(OP_EN), .OP_R_IN1(OP_R_IN1), .OP_D_IN1(OP_D_IN1),
      .OP_R_IN2(OP_R_IN2), .OP_D_IN2(OP_D_IN2),
      .OP_R_OUT(OP_R_OUT), .OP_D_OUT(OP_D_OUT),
      .RES_R(RES_R), .RES_D(RES_D)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Shared operator: registered D_IN1 % D_IN2 (0 for a zero divisor), held while EN=0.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OP_R_OUT <= 1'b0;
         OP_D_OUT <= '0;
      end else if (OP_EN) begin
         OP_R_OUT <= OP_R_IN1 & OP_R_IN2;
         OP_D_OUT <= (OP_D_IN2 == '0) ? '0 : OP_D_IN1 % OP_D_IN2;
      end
   end

   logic disp_seen;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) disp_seen <= 1'b0;
      else      disp_seen <= OP_R_IN1 & OP_EN;
   end
   always @(negedge CLK) begin
      if (RST && disp_seen) begin
         a_op_r_out: assert (OP_R_OUT === 1'b1)
            else $error("protocol error: OP_R_OUT low while a result is in flight");
      end
   end

   // ---------------- behavioural model ----------------
   typedef struct {int idx; logic [N-1:0] val; int due;} res_t;
   bit           m_f1 [NR];
   bit           m_f2 [NR];
   logic [N-1:0] m_a  [NR];
   logic [N-1:0] m_b  [NR];
   logic [N-1:0] m_res[NR];
   int           m_rr;
   res_t         m_q[$];
   int           e_win;
   logic [NR-1:0]   e_ack1, e_ack2, e_resr;
   logic [NR*N-1:0] e_resd;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_f1[i] = 0; m_f2[i] = 0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0;
      end
      m_rr = NR - 1;
      m_q.delete();
   endtask

   task automatic model_eval();
      e_win = -1;
      if (EN) begin
         for (int k = 1; k <= NR; k++) begin
            int j;
            j = (m_rr + k) % NR;
            if (e_win < 0 && m_f1[j] && m_f2[j]) e_win = j;
         end
      end
      for (int i = 0; i < NR; i++) begin
         e_ack1[i] = EN && REQ_R1[i] && (!m_f1[i] || e_win == i);
         e_ack2[i] = EN && REQ_R2[i] && (!m_f2[i] || e_win == i);
      end
      e_resr = '0;
      foreach (m_q[k]) begin
         if (m_q[k].due == cyc) begin
            e_resr[m_q[k].idx] = 1'b1;
            m_res[m_q[k].idx]  = m_q[k].val;
         end
      end
      for (int i = 0; i < NR; i++) e_resd[i*N +: N] = m_res[i];
   endtask

   task automatic model_advance();
      res_t r;
      while (m_q.size() > 0 && m_q[0].due <= cyc) void'(m_q.pop_front());
      if (e_win >= 0) begin
         r.idx = e_win;
         r.val = (m_b[e_win] == '0) ? '0 : m_a[e_win] % m_b[e_win];
         r.due = cyc + 2;
         m_q.push_back(r);
         m_rr = e_win;
      end
      for (int i = 0; i < NR; i++) begin
         if (e_ack1[i]) begin m_f1[i] = 1; m_a[i] = REQ_D1[i*N +: N]; end
         else if (e_win == i) m_f1[i] = 0;
         if (e_ack2[i]) begin m_f2[i] = 1; m_b[i] = REQ_D2[i*N +: N]; end
         else if (e_win == i) m_f2[i] = 0;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic set1(input int i, input logic r, input logic [N-1:0] d);
      REQ_R1[i] = r;
      REQ_D1[i*N +: N] = d;
   endtask

   task automatic set2(input int i, input logic r, input logic [N-1:0] d);
      REQ_R2[i] = r;
      REQ_D2[i*N +: N] = d;
   endtask

   task automatic clr();
      REQ_R1 = '0;
      REQ_R2 = '0;
   endtask

   function automatic logic [N-1:0] rd(input int i);
      return RES_D[i*N +: N];
   endfunction

   task automatic do_reset();
      RST = 1'b0;
      EN  = 1'b1;
      clr();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b0; EN = 1'b1;
      REQ_R1 = '1; REQ_R2 = '1;
      REQ_D1 = {$urandom, $urandom}; REQ_D2 = {$urandom, $urandom};
      repeat (2) @(posedge CLK);
      sample();
      n_cmp++; if (REQ_ACK1 !== '0 || REQ_ACK2 !== '0) begin
         n_err++; $display("FAIL reset_ack: got %b/%b want 0/0", REQ_ACK1, REQ_ACK2);
      end
      n_cmp++; if (OP_EN !== 1'b0 || OP_R_IN1 !== 1'b0 || OP_D_IN1 !== '0) begin
         n_err++; $display("FAIL reset_op: got en=%b r=%b d=%h want 0/0/0", OP_EN, OP_R_IN1, OP_D_IN1);
      end
      n_cmp++; if (RES_R !== '0 || RES_D !== '0) begin
         n_err++; $display("FAIL reset_res: got %b/%h want 0/0", RES_R, RES_D);
      end
      @(posedge CLK); #1;
      clr(); RST = 1'b1;
      sample();
      n_cmp++; if (OP_EN !== 1'b1 || OP_R_IN1 !== 1'b0) begin
         n_err++; $display("FAIL reset_release: got en=%b r=%b want 1/0", OP_EN, OP_R_IN1);
      end
      tick();
   endtask

   task automatic test_single();
      set1(0, 1, 17); set2(0, 1, 5);
      sample();
      n_cmp++; if (REQ_ACK1 !== 4'b0001 || REQ_ACK2 !== 4'b0001) begin
         n_err++; $display("FAIL single_ack: got %b/%b want 0001/0001", REQ_ACK1, REQ_ACK2);
      end
      tick(); clr();
      sample();
      n_cmp++; if ({OP_R_IN1, OP_R_IN2} !== 2'b11 || OP_D_IN1 !== 16'd17 || OP_D_IN2 !== 16'd5) begin
         n_err++; $display("FAIL single_disp: got r=%b%b d=%0d/%0d want 11 17/5",
                           OP_R_IN1, OP_R_IN2, OP_D_IN1, OP_D_IN2);
      end
      tick(); sample();
      n_cmp++; if (RES_R !== 4'b0000) begin
         n_err++; $display("FAIL single_early: got %b want 0000", RES_R);
      end
      tick(); sample();
      n_cmp++; if (RES_R !== 4'b0001 || rd(0) !== 16'd2) begin
         n_err++; $display("FAIL single_res: got %b/%0d want 0001/2", RES_R, rd(0));
      end
      tick(); sample();
      n_cmp++; if (RES_R !== 4'b0000 || rd(0) !== 16'd2) begin
         n_err++; $display("FAIL single_hold: got %b/%0d want 0000/2", RES_R, rd(0));
      end
      tick();
   endtask

   task automatic test_join();
      for (int c = 0; c < 8; c++) begin
         clr();
         if (c == 0) set1(2, 1, 100);
         if (c == 4) set2(2, 1, 7);
         sample();
         if (c == 0) begin
            n_cmp++; if (REQ_ACK1 !== 4'b0100 || REQ_ACK2 !== 4'b0000) begin
               n_err++; $display("FAIL join_ack1: got %b/%b want 0100/0000", REQ_ACK1, REQ_ACK2);
            end
         end
         if (c == 4) begin
            n_cmp++; if (REQ_ACK2 !== 4'b0100) begin
               n_err++; $display("FAIL join_ack2: got %b want 0100", REQ_ACK2);
            end
         end
         if (c >= 1 && c <= 6) begin
            n_cmp++; if (OP_R_IN1 !== (c == 5)) begin
               n_err++; $display("FAIL join_disp c%0d: got %b want %b", c, OP_R_IN1, c == 5);
            end
         end
         if (c == 5) begin
            n_cmp++; if (OP_D_IN1 !== 16'd100 || OP_D_IN2 !== 16'd7) begin
               n_err++; $display("FAIL join_opnd: got %0d/%0d want 100/7", OP_D_IN1, OP_D_IN2);
            end
         end
         if (c == 7) begin
            n_cmp++; if (RES_R !== 4'b0100 || rd(2) !== 16'd2) begin
               n_err++; $display("FAIL join_res: got %b/%0d want 0100/2", RES_R, rd(2));
            end
         end
         tick();
      end
   endtask

   task automatic test_all_full();
      int unsigned dv[4];
      int unsigned rs[4];
      dv = '{3, 3, 5, 4};
      rs = '{1, 2, 2, 1};
      do_reset();
      for (int c = 0; c < 8; c++) begin
         clr();
         if (c == 0) for (int i = 0; i < NR; i++) begin
            set1(i, 1, N'(10 + i)); set2(i, 1, N'(dv[i]));
         end
         sample();
         if (c == 0) begin
            n_cmp++; if (REQ_ACK1 !== 4'b1111 || REQ_ACK2 !== 4'b1111) begin
               n_err++; $display("FAIL full_ack: got %b/%b want 1111/1111", REQ_ACK1, REQ_ACK2);
            end
         end
         if (c >= 1 && c <= 4) begin
            n_cmp++;
            if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== N'(9 + c) || OP_D_IN2 !== N'(dv[c-1])) begin
               n_err++; $display("FAIL full_order c%0d: got %b %0d/%0d want 1 %0d/%0d",
                                 c, OP_R_IN1, OP_D_IN1, OP_D_IN2, 9 + c, dv[c-1]);
            end
         end
         if (c >= 3 && c <= 6) begin
            n_cmp++; if (RES_R !== NR'(1 << (c - 3)) || rd(c - 3) !== N'(rs[c-3])) begin
               n_err++; $display("FAIL full_res c%0d: got %b/%0d want %b/%0d",
                                 c, RES_R, rd(c - 3), NR'(1 << (c - 3)), rs[c-3]);
            end
         end
         tick();
      end
   endtask

   task automatic test_fairness();
      int g;
      do_reset();
      set1(1, 1, 50); set2(1, 1, 7); set1(3, 1, 60); set2(3, 1, 7);
      for (int c = 0; c < 9; c++) begin
         g = (c % 2 == 1) ? 1 : 3;
         sample();
         if (c == 0) begin
            n_cmp++; if (REQ_ACK1 !== 4'b1010 || REQ_ACK2 !== 4'b1010) begin
               n_err++; $display("FAIL fair_ack0: got %b/%b want 1010/1010", REQ_ACK1, REQ_ACK2);
            end
         end else begin
            n_cmp++;
            if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== N'(g == 1 ? 50 : 60) || REQ_ACK1 !== NR'(1 << g)) begin
               n_err++; $display("FAIL fair_grant c%0d: got %b %0d ack %b want 1 %0d ack %b",
                                 c, OP_R_IN1, OP_D_IN1, REQ_ACK1, g == 1 ? 50 : 60, NR'(1 << g));
            end
         end
         if (c >= 3) begin
            n_cmp++; if (RES_R !== NR'(1 << g) || rd(g) !== N'(g == 1 ? 1 : 4)) begin
               n_err++; $display("FAIL fair_res c%0d: got %b/%0d want %b/%0d",
                                 c, RES_R, rd(g), NR'(1 << g), g == 1 ? 1 : 4);
            end
         end
         tick();
      end
      clr();
      repeat (6) tick();
   endtask

   task automatic test_div_zero();
      for (int c = 0; c < 5; c++) begin
         clr();
         if (c == 0) begin set1(1, 1, 9); set2(1, 1, 0); end
         sample();
         if (c == 1) begin
            n_cmp++; if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== 16'd9 || OP_D_IN2 !== 16'd0) begin
               n_err++; $display("FAIL dz_disp: got %b %0d/%0d want 1 9/0", OP_R_IN1, OP_D_IN1, OP_D_IN2);
            end
         end
         if (c == 3) begin
            n_cmp++; if (RES_R !== 4'b0010 || rd(1) !== 16'd0) begin
               n_err++; $display("FAIL dz_res: got %b/%0d want 0010/0", RES_R, rd(1));
            end
         end
         tick();
      end
   endtask

   task automatic test_en_drop();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         clr();
         EN = !(c >= 2 && c <= 5);
         if (c == 0) begin set1(0, 1, 20); set2(0, 1, 6); set1(1, 1, 31); set2(1, 1, 4); end
         if (c >= 2 && c <= 6) set1(2, 1, 77);
         sample();
         if (c == 0) begin
            n_cmp++; if (REQ_ACK1 !== 4'b0011) begin
               n_err++; $display("FAIL en_ack0: got %b want 0011", REQ_ACK1);
            end
         end
         if (c == 1) begin
            n_cmp++; if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== 16'd20) begin
               n_err++; $display("FAIL en_disp0: got %b/%0d want 1/20", OP_R_IN1, OP_D_IN1);
            end
         end
         if (c >= 2 && c <= 5) begin
            n_cmp++; if (OP_EN !== 1'b0 || OP_R_IN1 !== 1'b0 || REQ_ACK1 !== 4'b0000) begin
               n_err++; $display("FAIL en_off c%0d: got en=%b r=%b ack=%b want 0/0/0000",
                                 c, OP_EN, OP_R_IN1, REQ_ACK1);
            end
            n_cmp++; if (RES_R !== ((c == 3) ? 4'b0001 : 4'b0000)) begin
               n_err++; $display("FAIL en_res c%0d: got %b want %b", c, RES_R,
                                 (c == 3) ? 4'b0001 : 4'b0000);
            end
         end
         if (c == 3) begin
            n_cmp++; if (rd(0) !== 16'd2) begin
               n_err++; $display("FAIL en_res_d: got %0d want 2", rd(0));
            end
         end
         if (c == 6) begin
            n_cmp++; if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== 16'd31 || REQ_ACK1 !== 4'b0100) begin
               n_err++; $display("FAIL en_resume: got %b %0d ack %b want 1 31 ack 0100",
                                 OP_R_IN1, OP_D_IN1, REQ_ACK1);
            end
         end
         if (c == 8) begin
            n_cmp++; if (RES_R !== 4'b0010 || rd(1) !== 16'd3) begin
               n_err++; $display("FAIL en_res1: got %b/%0d want 0010/3", RES_R, rd(1));
            end
         end
         tick();
      end
      EN = 1'b1;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      set1(1, 1, 40); set2(1, 1, 7); set1(2, 1, 55);
      sample();
      n_cmp++; if (REQ_ACK1 !== 4'b0110 || REQ_ACK2 !== 4'b0010) begin
         n_err++; $display("FAIL rst_ack0: got %b/%b want 0110/0010", REQ_ACK1, REQ_ACK2);
      end
      tick(); clr();
      sample();
      n_cmp++; if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== 16'd40) begin
         n_err++; $display("FAIL rst_disp: got %b/%0d want 1/40", OP_R_IN1, OP_D_IN1);
      end
      tick();
      RST = 1'b0;
      set1(0, 1, 99); set2(0, 1, 3);
      for (int c = 0; c < 2; c++) begin
         sample();
         n_cmp++;
         if (REQ_ACK1 !== '0 || REQ_ACK2 !== '0 || RES_R !== '0 || OP_EN !== 1'b0 || OP_R_IN1 !== 1'b0) begin
            n_err++; $display("FAIL rst_hold c%0d: got ack=%b/%b res=%b en=%b r=%b want all 0",
                              c, REQ_ACK1, REQ_ACK2, RES_R, OP_EN, OP_R_IN1);
         end
         tick();
      end
      RST = 1'b1; clr(); set2(2, 1, 5);
      sample();
      n_cmp++; if (REQ_ACK2 !== 4'b0100 || RES_R !== 4'b0000 || rd(1) !== 16'd0) begin
         n_err++; $display("FAIL rst_release: got ack2=%b res=%b d1=%0d want 0100/0000/0",
                           REQ_ACK2, RES_R, rd(1));
      end
      tick(); clr();
      for (int c = 0; c < 2; c++) begin
         sample();
         n_cmp++; if (OP_R_IN1 !== 1'b0 || RES_R !== 4'b0000) begin
            n_err++; $display("FAIL rst_empty c%0d: got r=%b res=%b want 0/0000", c, OP_R_IN1, RES_R);
         end
         tick();
      end
      set1(0, 1, 70); set2(0, 1, 9); set1(2, 1, 80);
      sample();
      n_cmp++; if (REQ_ACK1 !== 4'b0101) begin
         n_err++; $display("FAIL rst_refill: got %b want 0101", REQ_ACK1);
      end
      tick(); clr();
      sample();
      n_cmp++; if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== 16'd70) begin
         n_err++; $display("FAIL rst_rr_first: got %b/%0d want 1/70", OP_R_IN1, OP_D_IN1);
      end
      tick(); sample();
      n_cmp++; if (OP_R_IN1 !== 1'b1 || OP_D_IN1 !== 16'd80 || OP_D_IN2 !== 16'd5) begin
         n_err++; $display("FAIL rst_rr_second: got %b %0d/%0d want 1 80/5", OP_R_IN1, OP_D_IN1, OP_D_IN2);
      end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] x1, x2;
      do_reset();
      model_reset();
      REQ_D1 = '0; REQ_D2 = '0;
      for (int t = 0; t < 500; t++) begin
         sample();
         model_eval();
         x1 = (e_win >= 0) ? m_a[e_win] : '0;
         x2 = (e_win >= 0) ? m_b[e_win] : '0;
         n_cmp++; if (REQ_ACK1 !== e_ack1 || REQ_ACK2 !== e_ack2) begin
            n_err++; $display("FAIL rnd_ack t%0d: got %b/%b want %b/%b", t, REQ_ACK1, REQ_ACK2, e_ack1, e_ack2);
         end
         n_cmp++;
         if (OP_R_IN1 !== (e_win >= 0) || OP_R_IN2 !== (e_win >= 0) || OP_D_IN1 !== x1 || OP_D_IN2 !== x2) begin
            n_err++; $display("FAIL rnd_op t%0d: got %b%b %h/%h want %b %h/%h",
                              t, OP_R_IN1, OP_R_IN2, OP_D_IN1, OP_D_IN2, e_win >= 0, x1, x2);
         end
         n_cmp++; if (OP_EN !== EN) begin
            n_err++; $display("FAIL rnd_open t%0d: got %b want %b", t, OP_EN, EN);
         end
         n_cmp++; if (RES_R !== e_resr || RES_D !== e_resd) begin
            n_err++; $display("FAIL rnd_res t%0d: got %b %h want %b %h", t, RES_R, RES_D, e_resr, e_resd);
         end
         model_advance();
         tick();
         EN = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < NR; i++) begin
            if (!REQ_R1[i] || e_ack1[i]) set1(i, ($urandom_range(0, 2) != 0), N'($urandom));
            if (!REQ_R2[i] || e_ack2[i]) set2(i, ($urandom_range(0, 2) != 0), N'($urandom_range(0, 12)));
         end
      end
      clr();
      EN = 1'b1;
   endtask

   initial begin
      REQ_D1 = '0; REQ_D2 = '0; clr(); EN = 1'b1; RST = 1'b0;
      test_reset();
      test_single();
      test_join();
      test_all_full();
      test_fairness();
      test_div_zero();
      test_en_drop();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
